// File: rtl/mmio_port_responder.sv
// Memory-mapped port responder for the MIPS load/store bus: drives PortOut
// from stores, synchronizes PortIn and queues every input change in a FIFO
// that the core drains with loads from FIFO_DATA.
module mmio_port_responder #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                IRQ
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    OFF_PORT_OUT  = 3'd0,
    OFF_PORT_IN   = 3'd1,
    OFF_STATUS    = 3'd2,
    OFF_FIFO_DATA = 3'd3,
    OFF_CTRL      = 3'd4
  } regSel_e;

  logic [IN_WIDTH-1:0] sync1, sync2, prev;
  logic [IN_WIDTH-1:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0]       rdPtr, wrPtr;
  logic [CW-1:0]       count;
  logic                overflow, irqEn;

  logic [31:0] byteOff, wordOff;
  logic        hit;
  regSel_e     sel;
  logic        full, empty, pushReq, popReq, ctrlWr, flush;
  logic        doPush, doPop, ovfSet;
  logic [31:0] status;

  // Address decode: the shift discards the byte-lane bits of the offset.
  always_comb begin
    byteOff = Address - BASE_ADDR;
    wordOff = byteOff >> 2;
    hit     = wordOff < 32'd5;
    sel     = regSel_e'(wordOff[2:0]);
  end

  // FIFO control: flush overrides push/pop; a push into a full FIFO survives
  // only if the same edge pops, otherwise it is dropped and flagged.
  always_comb begin
    full    = count == CW'(FIFO_DEPTH);
    empty   = count == '0;
    pushReq = sync2 != prev;
    popReq  = hit && MemRead && (sel == OFF_FIFO_DATA) && !empty;
    ctrlWr  = hit && MemWrite && (sel == OFF_CTRL);
    flush   = ctrlWr && WriteData[1];
    doPush  = pushReq && (!full || popReq) && !flush;
    doPop   = popReq && !flush;
    ovfSet  = pushReq && full && !popReq;
    status  = {24'h0, 4'(count), 1'b0, overflow, full, !empty};
  end

  // Load data mux, purely combinational from Address.
  always_comb begin
    ReadData = '0;
    if (hit) begin
      case (sel)
        OFF_PORT_OUT:  ReadData = PortOut;
        OFF_PORT_IN:   ReadData = 32'(sync2);
        OFF_STATUS:    ReadData = status;
        OFF_FIFO_DATA: ReadData = empty ? '0 : 32'(fifoMem[rdPtr]);
        OFF_CTRL:      ReadData = {29'h0, irqEn, 2'b00};
        default:       ReadData = '0;
      endcase
    end
  end

  // Input synchronizer and change-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= sync2;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  // Registers written by stores, sticky overflow and the lagged IRQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut  <= '0;
      irqEn    <= 1'b0;
      overflow <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (hit && MemWrite && (sel == OFF_PORT_OUT)) PortOut <= WriteData;
      if (ctrlWr) irqEn <= WriteData[2];
      if (ovfSet)                       overflow <= 1'b1;
      else if (ctrlWr && WriteData[0])  overflow <= 1'b0;
      IRQ <= !empty && irqEn;
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder with hand-computed expectations.
module tb_mmio_port_responder;

  localparam logic [31:0] B       = 32'h1001_0040;
  localparam logic [31:0] A_OUT   = B + 32'h00;
  localparam logic [31:0] A_IN    = B + 32'h04;
  localparam logic [31:0] A_STAT  = B + 32'h08;
  localparam logic [31:0] A_FIFO  = B + 32'h0C;
  localparam logic [31:0] A_CTRL  = B + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, IRQ;
  logic [7:0]  PortIn;

  int unsigned nTests = 0;
  int unsigned nFail  = 0;

  mmio_port_responder #(
    .IN_WIDTH(8),
    .BASE_ADDR(32'h1001_0040),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
    .PortIn(PortIn), .PortOut(PortOut), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  // Non-popping read: no edge consumed.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b0;
    #1 d = ReadData;
  endtask

  // Load from FIFO_DATA across one edge.
  task automatic pop(output logic [31:0] d);
    Address = A_FIFO; MemRead = 1'b1;
    #1 d = ReadData;
    tick();
    MemRead = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0;
    MemRead = 1'b0; PortIn = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    check("rst PortOut", PortOut, 32'h0);
    check("rst IRQ", {31'h0, IRQ}, 32'h0);
    rd(A_STAT, d); check("rst STATUS", d, 32'h0);

    // PORT_OUT store/load, read-only and out-of-window stores ignored
    store(A_OUT, 32'hA5A5_0001);
    check("PortOut store", PortOut, 32'hA5A5_0001);
    rd(A_OUT, d); check("PORT_OUT load", d, 32'hA5A5_0001);
    store(A_IN, 32'hDEAD_BEEF);
    check("RO store ignored", PortOut, 32'hA5A5_0001);
    store(B + 32'h20, 32'h1111_2222);
    check("out-of-window store", PortOut, 32'hA5A5_0001);
    rd(B + 32'h14, d); check("read past window", d, 32'h0);
    rd(B - 32'h4, d);  check("read below window", d, 32'h0);
    rd(A_OUT + 32'h3, d); check("byte lane ignored", d, 32'hA5A5_0001);

    // Single change through synchronizer and FIFO
    PortIn = 8'd3;
    tick(); tick();
    rd(A_IN, d);   check("PORT_IN after 2", d, 32'h3);
    rd(A_STAT, d); check("STATUS after 2", d, 32'h0);
    tick();
    rd(A_STAT, d); check("STATUS after 3", d, 32'h11);
    pop(d);        check("pop 3", d, 32'h3);
    rd(A_STAT, d); check("STATUS drained", d, 32'h0);
    pop(d);        check("pop empty", d, 32'h0);
    rd(A_STAT, d); check("STATUS empty pop", d, 32'h0);

    // Five changes overflow a 4-deep FIFO
    PortIn = 8'd1; tick();
    PortIn = 8'd2; tick();
    PortIn = 8'd3; tick();
    PortIn = 8'd4; tick();
    PortIn = 8'd5; tick();
    tick(); tick();
    rd(A_STAT, d); check("STATUS overflow", d, 32'h47);
    pop(d); check("ovf pop1", d, 32'h1);
    pop(d); check("ovf pop2", d, 32'h2);
    pop(d); check("ovf pop3", d, 32'h3);
    pop(d); check("ovf pop4", d, 32'h4);
    rd(A_STAT, d); check("STATUS sticky ovf", d, 32'h04);
    store(A_CTRL, 32'h1);
    rd(A_STAT, d); check("STATUS ovf cleared", d, 32'h0);

    // Full FIFO with pop and push on the same edge
    PortIn = 8'd6; tick();
    PortIn = 8'd7; tick();
    PortIn = 8'd8; tick();
    PortIn = 8'd9; tick();
    tick(); tick();
    rd(A_STAT, d); check("STATUS full", d, 32'h43);
    PortIn = 8'd10; tick(); tick();
    pop(d);        check("full pop+push", d, 32'h6);
    rd(A_STAT, d); check("STATUS full kept", d, 32'h43);
    pop(d); check("wrap pop7", d, 32'h7);
    pop(d); check("wrap pop8", d, 32'h8);
    pop(d); check("wrap pop9", d, 32'h9);
    pop(d); check("wrap pop10", d, 32'hA);
    rd(A_STAT, d); check("STATUS after wrap", d, 32'h0);

    // IRQ enable and flush
    PortIn = 8'd11; tick(); tick(); tick();
    rd(A_STAT, d); check("STATUS one entry", d, 32'h11);
    store(A_CTRL, 32'h4);
    check("IRQ lag", {31'h0, IRQ}, 32'h0);
    rd(A_CTRL, d); check("CTRL read", d, 32'h4);
    tick();
    check("IRQ set", {31'h0, IRQ}, 32'h1);
    store(A_CTRL, 32'h6);
    rd(A_STAT, d); check("STATUS flushed", d, 32'h0);
    check("IRQ still lagging", {31'h0, IRQ}, 32'h1);
    tick();
    check("IRQ cleared", {31'h0, IRQ}, 32'h0);

    // Asynchronous reset mid-traffic, then nonzero PortIn at release
    store(A_OUT, 32'h1234_5678);
    PortIn = 8'd12; tick(); tick(); tick();
    tick();
    check("IRQ pre-reset", {31'h0, IRQ}, 32'h1);
    #2 reset = 1'b0;
    Address = A_STAT;
    #1;
    check("async rst PortOut", PortOut, 32'h0);
    check("async rst STATUS", ReadData, 32'h0);
    check("async rst IRQ", {31'h0, IRQ}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    rd(A_CTRL, d); check("rst CTRL", d, 32'h0);
    tick(); tick();
    rd(A_STAT, d); check("release STATUS 2", d, 32'h0);
    tick();
    rd(A_STAT, d); check("release change pushed", d, 32'h11);
    tick();
    check("IRQ disabled after rst", {31'h0, IRQ}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
